// File: rtl/prog_loader.sv
// Program loader: assembles a framed, checksummed byte stream into 25-bit
// instruction words, writes them to InstMEM and holds the core until a load completes.
module prog_loader #(
  parameter int          INST_W = 25,
  parameter int          ADDR_W = 8,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [7:0]        ByteIn,
  input  logic              ByteValid,
  output logic              ByteReady,
  output logic              InstWrite,
  output logic [ADDR_W-1:0] InstAddress,
  output logic [INST_W-1:0] InstData,
  output logic              CoreHold,
  output logic              LoadDone,
  output logic              LoadError
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int ASM_W = INST_W - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_e;

  state_e              state_q,       state_d;
  logic                byte_ready_q,  byte_ready_d;
  logic                inst_write_q,  inst_write_d;
  logic [ADDR_W-1:0]   inst_addr_q,   inst_addr_d;
  logic [INST_W-1:0]   inst_data_q,   inst_data_d;
  logic                core_hold_q,   core_hold_d;
  logic                load_done_q,   load_done_d;
  logic                load_error_q,  load_error_d;
  logic [ASM_W-1:0]    asm_q,         asm_d;
  logic [1:0]          byte_cnt_q,    byte_cnt_d;
  logic [CNT_W-1:0]    inst_cnt_q,    inst_cnt_d;
  logic [7:0]          csum_q,        csum_d;
  logic                accept;

  assign accept = ByteValid && byte_ready_q;

  always_comb begin
    // NOTE: every _d starts from its held value so no path through the case infers a latch.
    state_d      = state_q;
    inst_write_d = 1'b0;
    inst_addr_d  = inst_addr_q;
    inst_data_d  = inst_data_q;
    asm_d        = asm_q;
    byte_cnt_d   = byte_cnt_q;
    inst_cnt_d   = inst_cnt_q;
    csum_d       = csum_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (accept && ByteIn == HDR) state_d = S_COUNT;
      end

      S_COUNT: begin
        if (accept) begin
          // A count of zero stands for a full 256-instruction image.
          inst_cnt_d  = (ByteIn == 8'd0) ? CNT_W'(256) : CNT_W'(ByteIn);
          csum_d      = ByteIn;
          inst_addr_d = '0;
          byte_cnt_d  = 2'd0;
          state_d     = S_DATA;
        end
      end

      S_DATA: begin
        if (accept) begin
          csum_d = csum_q + ByteIn;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            // Only bit 0 of the top byte lands in the word; anything else is a corrupt image.
            if (ByteIn[7:1] != 7'd0) begin
              state_d = S_ERR;
            end else begin
              inst_data_d  = {ByteIn[0], asm_q};
              inst_write_d = 1'b1;
              state_d      = S_WRITE;
            end
          end else begin
            asm_d      = {ByteIn, asm_q[ASM_W-1:8]};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      S_WRITE: begin
        inst_addr_d = inst_addr_q + 1'b1;
        inst_cnt_d  = inst_cnt_q - CNT_W'(1);
        state_d     = (inst_cnt_q == CNT_W'(1)) ? S_CHECK : S_DATA;
      end

      S_CHECK: begin
        if (accept) state_d = (ByteIn == csum_q) ? S_DONE : S_ERR;
      end

      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    byte_ready_d = (state_d != S_WRITE);
    core_hold_d  = (state_d != S_DONE);
    load_done_d  = (state_d == S_DONE);
    load_error_d = (state_d == S_ERR);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      byte_ready_q <= 1'b0;
      inst_write_q <= 1'b0;
      inst_addr_q  <= '0;
      inst_data_q  <= '0;
      core_hold_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      asm_q        <= '0;
      byte_cnt_q   <= 2'd0;
      inst_cnt_q   <= '0;
      csum_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= byte_ready_d;
      inst_write_q <= inst_write_d;
      inst_addr_q  <= inst_addr_d;
      inst_data_q  <= inst_data_d;
      core_hold_q  <= core_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      asm_q        <= asm_d;
      byte_cnt_q   <= byte_cnt_d;
      inst_cnt_q   <= inst_cnt_d;
      csum_q       <= csum_d;
    end
  end

  assign ByteReady   = byte_ready_q;
  assign InstWrite   = inst_write_q;
  assign InstAddress = inst_addr_q;
  assign InstData    = inst_data_q;
  assign CoreHold    = core_hold_q;
  assign LoadDone    = load_done_q;
  assign LoadError   = load_error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framed loads, checksum/format errors,
// junk rejection, mid-load reset and stalled handshakes.
module tb_prog_loader;

  localparam logic [7:0] HDR = 8'hA5;

  logic        clk;
  logic        Reset;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        InstWrite;
  logic [7:0]  InstAddress;
  logic [24:0] InstData;
  logic        CoreHold;
  logic        LoadDone;
  logic        LoadError;

  prog_loader dut (
    .clk         (clk),
    .Reset       (Reset),
    .ByteIn      (ByteIn),
    .ByteValid   (ByteValid),
    .ByteReady   (ByteReady),
    .InstWrite   (InstWrite),
    .InstAddress (InstAddress),
    .InstData    (InstData),
    .CoreHold    (CoreHold),
    .LoadDone    (LoadDone),
    .LoadError   (LoadError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write log filled on the falling edge, away from the DUT's active edge.
  logic [7:0]  wr_addr [0:511];
  logic [24:0] wr_data [0:511];
  int          wr_cnt = 0;
  int          wr_ready_bad = 0;

  always @(negedge clk) begin
    if (Reset && InstWrite) begin
      if (wr_cnt < 512) begin
        wr_addr[wr_cnt] = InstAddress;
        wr_data[wr_cnt] = InstData;
      end
      wr_cnt++;
      if (ByteReady) wr_ready_bad++;
    end
  end

  logic [7:0]  tx [0:1023];
  logic [24:0] exp_word [0:255];

  task automatic fill_word(input int idx, input logic [24:0] w);
    tx[4*idx]       = w[7:0];
    tx[4*idx + 1]   = w[15:8];
    tx[4*idx + 2]   = w[23:16];
    tx[4*idx + 3]   = {7'd0, w[24]};
    exp_word[idx]   = w;
  endtask

  // Returns right after the rising edge on which the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        ByteValid = 1'b0;
        ByteIn    = 8'($urandom);
      end
    end
    @(negedge clk);
    ByteIn    = b;
    ByteValid = 1'b1;
    budget    = 0;
    while (!ByteReady && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!ByteReady) check("byte_ready_timeout", 64'd0, 64'd1);
    else @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    ByteValid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic load_frame(input int n_inst, input logic [7:0] cs_xor, input bit gaps);
    logic [7:0] cs;
    cs = n_inst[7:0];
    send_byte(HDR, gaps);
    send_byte(n_inst[7:0], gaps);
    for (int i = 0; i < 4*n_inst; i++) begin
      send_byte(tx[i], gaps);
      cs = cs + tx[i];
    end
    send_byte(cs ^ cs_xor, gaps);
    #1;
  endtask

  task automatic check_writes(input string tag, input int n);
    int bad_addr;
    int bad_data;
    bad_addr = 0;
    bad_data = 0;
    check({tag, "_count"}, wr_cnt, n);
    for (int i = 0; i < n && i < wr_cnt; i++) begin
      if (wr_addr[i] !== 8'(i))      bad_addr++;
      if (wr_data[i] !== exp_word[i]) bad_data++;
    end
    check({tag, "_addr_bad"}, bad_addr, 0);
    check({tag, "_data_bad"}, bad_data, 0);
  endtask

  initial begin
    Reset     = 1'b0;
    ByteIn    = 8'h00;
    ByteValid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {ByteReady, InstWrite, InstAddress, InstData, CoreHold, LoadDone, LoadError},
          {1'b0, 1'b0, 8'h00, 25'h0, 1'b1, 1'b0, 1'b0});
    Reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", ByteReady, 1'b1);

    // Junk before the header is dropped in IDLE
    wr_cnt = 0;
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 0);
    #1;
    check("junk_no_load", {LoadDone, LoadError, CoreHold}, 3'b001);
    fill_word(0, 25'h1234567);
    load_frame(1, 8'h00, 0);
    check("junk_then_done", {LoadDone, LoadError, CoreHold}, 3'b100);
    idle(1);
    check_writes("junk", 1);

    // Back-to-back single instruction: A5 01 67 45 23 01 D1
    wr_cnt = 0;
    send_byte(8'hA5, 0);
    #1;
    check("hold_reasserts", CoreHold, 1'b1);
    send_byte(8'h01, 0);
    send_byte(8'h67, 0);
    send_byte(8'h45, 0);
    send_byte(8'h23, 0);
    #1;
    check("no_write_early", InstWrite, 1'b0);
    send_byte(8'h01, 0);
    #1;
    check("write_latency", {InstWrite, ByteReady}, 2'b10);
    check("write_addr", InstAddress, 8'h00);
    check("write_data", InstData, 25'h1234567);
    send_byte(8'hD1, 0);
    #1;
    check("b2b_done", {LoadDone, LoadError, CoreHold}, 3'b100);
    check("b2b_write_count", wr_cnt, 1);

    // Bad checksum D2, then a clean frame
    idle(1);
    wr_cnt = 0;
    load_frame(1, 8'h03, 0);
    check("cs_err_flags", {LoadDone, LoadError, CoreHold}, 3'b011);
    idle(1);
    check("cs_err_writes", wr_cnt, 1);
    check("cs_err_addr", wr_addr[0], 8'h00);
    load_frame(1, 8'h00, 0);
    check("after_err_done", {LoadDone, LoadError, CoreHold}, 3'b100);

    // Full 256-instruction image (count byte 00)
    idle(1);
    wr_cnt = 0;
    for (int i = 0; i < 256; i++)
      fill_word(i, {i[0], 8'h3C, ~i[7:0], i[7:0]});
    load_frame(256, 8'h00, 0);
    check("n0_done", {LoadDone, LoadError, CoreHold}, 3'b100);
    check("n0_addr_wrapped", InstAddress, 8'h00);
    idle(1);
    check_writes("n0", 256);

    // Top byte 02 is a format error on that byte, with no write
    wr_cnt = 0;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h02, 0);
    #1;
    check("fmt_err_flags", {InstWrite, LoadDone, LoadError, CoreHold}, 4'b0011);
    idle(2);
    check("fmt_err_no_write", wr_cnt, 0);

    // Reset mid-load after two data bytes
    wr_cnt = 0;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    ByteValid = 1'b0;
    Reset     = 1'b0;
    #1;
    check("midload_reset_outputs",
          {ByteReady, InstWrite, InstAddress, InstData, CoreHold, LoadDone, LoadError},
          {1'b0, 1'b0, 8'h00, 25'h0, 1'b1, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    fill_word(0, 25'h0ABCDEF);
    load_frame(1, 8'h00, 0);
    check("reset_reload_done", {LoadDone, LoadError, CoreHold}, 3'b100);
    idle(1);
    check_writes("reset_reload", 1);

    // Randomly stalled handshake across a 3-instruction frame
    wr_cnt       = 0;
    wr_ready_bad = 0;
    fill_word(0, 25'h1234567);
    fill_word(1, 25'h0543210);
    fill_word(2, 25'h1ADBEEF);
    load_frame(3, 8'h00, 1);
    check("gaps_done", {LoadDone, LoadError, CoreHold}, 3'b100);
    idle(1);
    check_writes("gaps", 3);
    check("ready_low_in_write", wr_ready_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
